// File: rtl/strng_sample_ctrl.sv
// Sample sequencer for the STR TRNG core: strobe divider, warm-up discard,
// repetition-count health test and a 4-entry first-word-fall-through output FIFO.
module strng_sample_ctrl #(
  parameter int DIV_W          = 8,
  parameter int WARMUP_SAMPLES = 256,
  parameter int RCT_LIMIT      = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  output logic             smp_en,
  input  logic [7:0]       rnd_in,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             fault,
  output logic             ovf,
  input  logic             clr_fault,
  output logic [2:0]       fifo_level
);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_FAULT} state_e;

  localparam logic [15:0] WARM_LAST = 16'(WARMUP_SAMPLES - 1);
  localparam logic [7:0]  RCT_LIM   = 8'(RCT_LIMIT);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             smp_q, smp_d;
  logic             cap_q, cap_d;
  logic [15:0]      warm_q, warm_d;
  logic [7:0]       rep_q, rep_d;
  logic [7:0]       prev_q, prev_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       wr_q, wr_d;
  logic [1:0]       rd_q, rd_d;
  logic [2:0]       lvl_q, lvl_d;
  logic [7:0]       mem_q [4];

  logic       active_q, active_d, div_hit;
  logic       capture, trip, warm_done, start;
  logic       pop, push_req, push, drop, flush;
  logic [7:0] rep_new;

  assign active_q  = (state_q == S_WARMUP) || (state_q == S_RUN);
  assign active_d  = (state_d == S_WARMUP) || (state_d == S_RUN);
  assign div_hit   = (div_q >= div_val);
  // The core presents its byte one cycle after the strobe; drop it if we have left WARMUP/RUN.
  assign capture   = cap_q && active_q;
  assign rep_new   = (rnd_in == prev_q) ? (rep_q + 8'd1) : 8'd1;
  assign trip      = capture && (rep_new == RCT_LIM);
  assign warm_done = capture && (state_q == S_WARMUP) && (warm_q == WARM_LAST);
  assign start     = (state_q == S_IDLE) && (state_d == S_WARMUP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (en) state_d = S_WARMUP;
      S_WARMUP: begin
        if (trip)           state_d = S_FAULT;
        else if (!en)       state_d = S_IDLE;
        else if (warm_done) state_d = S_RUN;
      end
      S_RUN: begin
        if (trip)     state_d = S_FAULT;
        else if (!en) state_d = S_IDLE;
      end
      S_FAULT:  if (clr_fault) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobe is suppressed when the next state is idle/fault so it never outlives a transition.
  always_comb begin
    div_d = '0;
    if (active_q && !div_hit) div_d = div_q + DIV_W'(1);
    smp_d = active_q && active_d && div_hit;
    cap_d = smp_q;
  end

  always_comb begin
    warm_d = warm_q;
    rep_d  = rep_q;
    prev_d = prev_q;
    if (start) begin
      warm_d = '0;
      rep_d  = '0;
      prev_d = '0;
    end else if (capture) begin
      rep_d  = rep_new;
      prev_d = rnd_in;
      if (state_q == S_WARMUP) warm_d = warm_q + 16'd1;
    end
  end

  // A push is allowed into a full FIFO only when the head leaves in the same cycle.
  assign pop      = (lvl_q != 3'd0) && out_ready;
  assign push_req = capture && (state_q == S_RUN) && !trip;
  assign push     = push_req && ((lvl_q != 3'd4) || pop);
  assign drop     = push_req && (lvl_q == 3'd4) && !pop;
  assign flush    = (state_d == S_FAULT) && (state_q != S_FAULT);

  always_comb begin
    wr_d  = wr_q + {1'b0, push};
    rd_d  = rd_q + {1'b0, pop};
    lvl_d = lvl_q + {2'b00, push} - {2'b00, pop};
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      lvl_d = '0;
    end
    ovf_d = ovf_q;
    if (clr_fault) ovf_d = 1'b0;
    if (drop)      ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      smp_q   <= 1'b0;
      cap_q   <= 1'b0;
      warm_q  <= '0;
      rep_q   <= '0;
      prev_q  <= '0;
      ovf_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      smp_q   <= smp_d;
      cap_q   <= cap_d;
      warm_q  <= warm_d;
      rep_q   <= rep_d;
      prev_q  <= prev_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      lvl_q   <= lvl_d;
      if (push) mem_q[wr_q] <= rnd_in;
    end
  end

  assign smp_en     = smp_q;
  assign out_data   = mem_q[rd_q];
  assign out_valid  = (lvl_q != 3'd0);
  assign busy       = (state_q == S_WARMUP);
  assign fault      = (state_q == S_FAULT);
  assign ovf        = ovf_q;
  assign fifo_level = lvl_q;

endmodule

// File: tb/tb_strng_sample_ctrl.sv
// Directed bench for strng_sample_ctrl; a tiny core model advances the raw byte
// after every strobe so each capture number maps to a known byte.
module tb_strng_sample_ctrl;

  logic       clk = 1'b0;
  logic       rstn, en, smpEn, outValid, outReady, busy, fault, ovf, clrFault;
  logic [7:0] divVal, rndIn, outData;
  logic [2:0] fifoLevel;
  logic       strobePrev, rndHold;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  strng_sample_ctrl #(
    .DIV_W(8),
    .WARMUP_SAMPLES(4),
    .RCT_LIMIT(32)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .en(en),
    .div_val(divVal),
    .smp_en(smpEn),
    .rnd_in(rndIn),
    .out_data(outData),
    .out_valid(outValid),
    .out_ready(outReady),
    .busy(busy),
    .fault(fault),
    .ovf(ovf),
    .clr_fault(clrFault),
    .fifo_level(fifoLevel)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Advance whole cycles; capture k after a start sees seed+k unless the byte is held.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (strobePrev && !rndHold) rndIn = rndIn + 8'd1;
      strobePrev = smpEn;
    end
  endtask

  task automatic applyReset(input logic [7:0] dv, input logic ready, input logic hold, input logic [7:0] seed);
    rstn       = 1'b0;
    en         = 1'b0;
    clrFault   = 1'b0;
    divVal     = dv;
    outReady   = ready;
    rndHold    = hold;
    rndIn      = seed;
    strobePrev = 1'b0;
    applyStimulus(2);
    rstn = 1'b1;
  endtask

  initial begin
    // Reset values and warm-up with a period of 3
    applyReset(8'd2, 1'b1, 1'b0, 8'h10);
    checkOutput("rst_smp_en", smpEn, 0);
    checkOutput("rst_out_valid", outValid, 0);
    checkOutput("rst_out_data", outData, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_fault", fault, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_level", fifoLevel, 0);
    en = 1'b1;
    applyStimulus(1);
    checkOutput("t1_busy_entry", busy, 1);
    checkOutput("t1_smp_entry", smpEn, 0);
    applyStimulus(2);
    checkOutput("t1_no_early_strobe", smpEn, 0);
    applyStimulus(1);
    checkOutput("t1_first_strobe", smpEn, 1);
    applyStimulus(1);
    checkOutput("t1_strobe_one_cycle", smpEn, 0);
    applyStimulus(2);
    checkOutput("t1_second_strobe", smpEn, 1);
    applyStimulus(7);
    checkOutput("t1_busy_last_warm", busy, 1);
    applyStimulus(1);
    checkOutput("t1_busy_run", busy, 0);
    checkOutput("t1_no_warm_output", outValid, 0);
    applyStimulus(3);
    checkOutput("t1_first_valid", outValid, 1);
    checkOutput("t1_first_byte", outData, 8'h15);
    checkOutput("t1_no_fault", fault, 0);
    applyStimulus(1);
    checkOutput("t1_popped", outValid, 0);
    checkOutput("t1_level_empty", fifoLevel, 0);

    // Fill with consumer stalled, overflow, clear ovf, then drain from IDLE
    applyReset(8'd0, 1'b0, 1'b0, 8'h10);
    en = 1'b1;
    applyStimulus(8);
    checkOutput("t2_level1", fifoLevel, 1);
    applyStimulus(1);
    checkOutput("t2_level2", fifoLevel, 2);
    applyStimulus(1);
    checkOutput("t2_level3", fifoLevel, 3);
    applyStimulus(1);
    checkOutput("t2_level4", fifoLevel, 4);
    checkOutput("t2_ovf_not_yet", ovf, 0);
    checkOutput("t2_head", outData, 8'h15);
    applyStimulus(1);
    checkOutput("t2_ovf_set", ovf, 1);
    checkOutput("t2_level_full", fifoLevel, 4);
    en = 1'b0;
    applyStimulus(1);
    checkOutput("t2_idle_smp", smpEn, 0);
    clrFault = 1'b1;
    applyStimulus(1);
    clrFault = 1'b0;
    checkOutput("t2_ovf_cleared", ovf, 0);
    checkOutput("t2_level_kept", fifoLevel, 4);
    checkOutput("t2_idle_busy", busy, 0);
    outReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checkOutput("t2_drain", outData, 32'h15 + k);
      applyStimulus(1);
    end
    checkOutput("t2_drained", outValid, 0);

    // Full FIFO with simultaneous pop and push keeps level and order
    applyReset(8'd0, 1'b0, 1'b0, 8'h10);
    en = 1'b1;
    applyStimulus(11);
    checkOutput("t4_full", fifoLevel, 4);
    outReady = 1'b1;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1);
      checkOutput("t4_level", fifoLevel, 4);
      checkOutput("t4_order", outData, 32'h16 + k);
    end
    checkOutput("t4_no_ovf", ovf, 0);

    // Repetition-count trip on a stuck byte
    applyReset(8'd0, 1'b0, 1'b1, 8'hA5);
    en = 1'b1;
    applyStimulus(34);
    checkOutput("t3_pre_trip_fault", fault, 0);
    checkOutput("t3_pre_trip_level", fifoLevel, 4);
    applyStimulus(1);
    checkOutput("t3_fault", fault, 1);
    checkOutput("t3_flushed", fifoLevel, 0);
    checkOutput("t3_flushed_valid", outValid, 0);
    checkOutput("t3_ovf_kept", ovf, 1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("t3_no_strobe", smpEn, 0);
      applyStimulus(1);
    end
    checkOutput("t3_still_fault", fault, 1);
    clrFault = 1'b1;
    applyStimulus(1);
    clrFault = 1'b0;
    checkOutput("t3_cleared", fault, 0);
    checkOutput("t3_ovf_cleared", ovf, 0);
    checkOutput("t3_idle_busy", busy, 0);
    applyStimulus(1);
    checkOutput("t3_rewarm", busy, 1);
    applyStimulus(1);
    checkOutput("t3_restrobe", smpEn, 1);

    // en dropped in RUN with three bytes queued and a capture pending
    applyReset(8'd3, 1'b0, 1'b0, 8'h10);
    en = 1'b1;
    applyStimulus(4);
    checkOutput("t5_no_early_strobe", smpEn, 0);
    applyStimulus(1);
    checkOutput("t5_first_strobe", smpEn, 1);
    applyStimulus(26);
    checkOutput("t5_level3", fifoLevel, 3);
    applyStimulus(2);
    checkOutput("t5_last_strobe", smpEn, 1);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1);
      checkOutput("t5_stopped", smpEn, 0);
    end
    checkOutput("t5_pending_discarded", fifoLevel, 3);
    outReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checkOutput("t5_drain", outData, 32'h15 + k);
      applyStimulus(1);
    end
    checkOutput("t5_drained", outValid, 0);

    // Asynchronous reset mid-WARMUP, then a full warm-up again
    applyReset(8'd0, 1'b0, 1'b0, 8'h10);
    en = 1'b1;
    applyStimulus(3);
    checkOutput("t6_in_warmup", busy, 1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("t6_async_busy", busy, 0);
    checkOutput("t6_async_smp", smpEn, 0);
    applyReset(8'd0, 1'b0, 1'b0, 8'h10);
    en = 1'b1;
    applyStimulus(6);
    checkOutput("t6_rewarm_busy", busy, 1);
    applyStimulus(1);
    checkOutput("t6_rewarm_done", busy, 0);
    checkOutput("t6_rewarm_no_valid", outValid, 0);
    applyStimulus(1);
    checkOutput("t6_rewarm_byte", outData, 8'h15);

    // Asynchronous reset mid-FAULT
    applyReset(8'd0, 1'b0, 1'b1, 8'hA5);
    en = 1'b1;
    applyStimulus(36);
    checkOutput("t6_in_fault", fault, 1);
    checkOutput("t6_fault_ovf", ovf, 1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("t6_async_fault", fault, 0);
    checkOutput("t6_async_ovf", ovf, 0);
    checkOutput("t6_async_data", outData, 0);
    applyReset(8'd0, 1'b1, 1'b0, 8'h10);
    en = 1'b1;
    applyStimulus(6);
    checkOutput("t6_restart_busy", busy, 1);
    applyStimulus(1);
    checkOutput("t6_restart_run", busy, 0);
    applyStimulus(1);
    checkOutput("t6_restart_valid", outValid, 1);
    checkOutput("t6_restart_byte", outData, 8'h15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/strng_sample_ctrl.md
Name: strng_sample_ctrl

Overview:
Sequencer for the STR TRNG core. It generates a programmable sample strobe (clock enable) for the core and discards a warm-up run of samples after each start. It runs a repetition-count health test on each captured byte. Accepted bytes go through a 4-entry FIFO to a valid/ready consumer. It sits between the board clock/reset logic and strng_core, and replaces the free-running gated sample clock.

Parameters:
DIV_W, 8, width of div_val and the internal divider counter
WARMUP_SAMPLES, 256, captured samples discarded after each start (range 1..65535)
RCT_LIMIT, 32, consecutive identical bytes that trip the fault (range 2..255)

Ports:
clk  in  1  system clock (50 MHz)
rstn  in  1  reset; one clock; reset is asynchronous and active-low
en  in  1  level; 1 = run generator
div_val  in  DIV_W  sample period = div_val+1 clk cycles
smp_en  out  1  one-cycle sample strobe to strng_core clock enable
rnd_in  in  8  raw byte from strng_core
out_data  out  8  FIFO head byte
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts out_data when out_valid=1
busy  out  1  1 in WARMUP
fault  out  1  1 in FAULT
ovf  out  1  sticky: a RUN sample was dropped because the FIFO was full
clr_fault  in  1  one-cycle pulse; clears FAULT and ovf
fifo_level  out  3  FIFO occupancy 0..4

Behaviour:
- Reset (async, rstn=0): state IDLE; smp_en=0, out_valid=0, out_data=0, busy=0, fault=0, ovf=0, fifo_level=0; divider, warm-up and repetition counters 0; prev byte 0.
- States: IDLE, WARMUP, RUN, FAULT.
  - IDLE: no strobes. en=1 -> WARMUP; the divider clears on entry.
  - WARMUP: strobes issued; each capture increments warm_cnt and is discarded. Capture number WARMUP_SAMPLES -> RUN. en=0 -> IDLE.
  - RUN: strobes issued; captures are pushed to the FIFO. en=0 -> IDLE.
  - FAULT: no strobes; the FIFO is flushed on the entry cycle. en is ignored. clr_fault=1 -> IDLE and ovf clears. Leaving FAULT always requires clr_fault.
  - clr_fault outside FAULT clears only ovf.
- Divider:
  - Counter increments each cycle in WARMUP/RUN.
  - When counter >= div_val: smp_en=1 that cycle and the counter returns to 0. A live div_val reduced below the counter therefore wraps immediately.
  - div_val=0 gives a strobe every cycle.
  - First strobe occurs div_val+1 cycles after entering WARMUP.
  - smp_en is registered; it is never high in IDLE/FAULT or in the cycle after a transition into them.
- Capture: rnd_in is sampled in the cycle after smp_en (core latency 1). A capture pending when the state leaves WARMUP/RUN is discarded.
- Repetition count test (WARMUP and RUN):
  - Captured byte == prev: rep_cnt+1. Otherwise rep_cnt=1. prev takes the new byte.
  - rep_cnt reaching RCT_LIMIT -> FAULT next cycle; the tripping byte is not pushed.
  - rep_cnt and prev clear on entering WARMUP. The first capture after start sets rep_cnt=1.
- FIFO (4 entries, first-word fall-through):
  - out_valid = level != 0; out_data = head. Pop on out_valid & out_ready.
  - Push when the capture is accepted in RUN and (level<4 or pop in the same cycle). Full with no pop: the byte is dropped and ovf is set.
  - Simultaneous push and pop: level unchanged, order preserved. Pointers wrap modulo 4.
  - FAULT entry: level=0, out_valid=0. Leaving RUN for IDLE keeps the FIFO contents for draining.

Test Plan:
1. WARMUP_SAMPLES=4, div_val=2, en=1, rnd_in incrementing, out_ready=1 -> smp_en every 3rd cycle (first 3 cycles after WARMUP entry); busy=1 for 4 captures; the 5th captured byte is the first out_valid byte; no fault.
2. div_val=0, out_ready=0, RUN -> fifo_level climbs 1..4; the 5th capture is dropped and ovf=1; clr_fault pulse -> ovf=0, FIFO unchanged.
3. rnd_in held at 8'hA5, RCT_LIMIT=32 -> fault=1 one cycle after the 32nd identical capture; FIFO flushed; smp_en stays 0 with en=1; clr_fault -> IDLE, then WARMUP again.
4. FIFO full, out_ready=1, capture in the same cycle -> level stays 4; the output sequence has no loss or reorder.
5. en dropped mid-RUN with 3 bytes queued -> no further smp_en; the 3 bytes drain in order; the pending capture is discarded.
6. rstn asserted mid-WARMUP and mid-FAULT -> all outputs 0 immediately (async); restart needs the full warm-up.
